// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the pipeline hazard controller (forwarding
//               select encoding and tracked-stage entry record).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Widest register address an entry can carry; narrower files zero-extend.
    localparam int unsigned c_rd_max_w = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [c_rd_max_w-1:0] rd;
        logic                  wre;
        logic                  load;
    } hz_entry_t;

endpackage

`default_nettype wire

// File: rtl/hz_match.sv
// ============================================================================
// Module      : hz_match
// Description : Flags a decode source operand that reads the register a
//               tracked pipeline entry is about to write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hz_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic                  i_dec_valid,
    input  logic [REG_AW-1:0]     i_src,
    input  logic                  i_src_use,
    input  logic                  i_valid,
    input  logic                  i_wre,
    input  logic [c_rd_max_w-1:0] i_rd,
    output logic                  o_hit
);

    assign o_hit = i_dec_valid & i_src_use & i_valid & i_wre
                 & (i_rd == c_rd_max_w'(i_src));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Tracks in-flight register writes after decode and produces
//               stall / flush / operand-forwarding controls. Forwarding is
//               built only when PIPE_HAZARD_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dec_valid,
    input  logic [REG_AW-1:0]      dec_rs1,
    input  logic [REG_AW-1:0]      dec_rs2,
    input  logic                   dec_rs1_use,
    input  logic                   dec_rs2_use,
    input  logic [REG_AW-1:0]      dec_rd,
    input  logic                   dec_wre,
    input  logic                   dec_load,
    input  logic                   ex_br_taken,
    output logic                   stall,
    output logic                   flush_fd,
    output logic                   flush_de,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [2**REG_AW-1:0]   busy_mask
);

    hz_entry_t           r_pipe [DEPTH];
    hz_entry_t           w_dec_entry;
    logic [DEPTH-1:0]    w_hit_a;
    logic [DEPTH-1:0]    w_hit_b;
    logic                w_hazard;
    logic                w_issue;
    fwd_sel_e            w_sel_a;
    fwd_sel_e            w_sel_b;
    logic [2**REG_AW-1:0] w_busy;
    logic                w_unused;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            hz_match #(.REG_AW(REG_AW)) u_match_a (
                .i_dec_valid (dec_valid),
                .i_src       (dec_rs1),
                .i_src_use   (dec_rs1_use),
                .i_valid     (r_pipe[i].valid),
                .i_wre       (r_pipe[i].wre),
                .i_rd        (r_pipe[i].rd),
                .o_hit       (w_hit_a[i])
            );
            hz_match #(.REG_AW(REG_AW)) u_match_b (
                .i_dec_valid (dec_valid),
                .i_src       (dec_rs2),
                .i_src_use   (dec_rs2_use),
                .i_valid     (r_pipe[i].valid),
                .i_wre       (r_pipe[i].wre),
                .i_rd        (r_pipe[i].rd),
                .o_hit       (w_hit_b[i])
            );
        end
    endgenerate

`ifdef PIPE_HAZARD_FWD_EN
    localparam int c_fwd_n = (DEPTH < 3) ? DEPTH : 3;

    // Walk oldest to youngest so the youngest forwarding stage wins.
    always_comb begin
        w_sel_a = FWD_RF;
        w_sel_b = FWD_RF;
        for (int i = c_fwd_n - 1; i >= 0; i--) begin
            if (w_hit_a[i]) w_sel_a = fwd_sel_e'(2'(i + 1));
            if (w_hit_b[i]) w_sel_b = fwd_sel_e'(2'(i + 1));
        end
    end

    assign w_hazard = (w_hit_a[0] | w_hit_b[0]) & r_pipe[0].load;
`else
    assign w_sel_a  = FWD_RF;
    assign w_sel_b  = FWD_RF;
    assign w_hazard = |(w_hit_a | w_hit_b);
`endif

    assign stall     = w_hazard & ~ex_br_taken;
    assign flush_fd  = ex_br_taken;
    assign flush_de  = ex_br_taken;
    assign fwd_a_sel = w_sel_a;
    assign fwd_b_sel = w_sel_b;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_pipe[i].valid && r_pipe[i].wre) w_busy[r_pipe[i].rd[REG_AW-1:0]] = 1'b1;
        end
    end

    assign busy_mask = w_busy;

    assign w_dec_entry = '{valid: 1'b1,
                           rd:    c_rd_max_w'(dec_rd),
                           wre:   dec_wre,
                           load:  dec_load};

    assign w_issue = dec_valid & ~stall & ~flush_de;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_issue ? w_dec_entry : '0;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // The retiring entry's load flag and far-stage hits have no consumer.
    assign w_unused = ^{r_pipe[DEPTH-1].load, w_hit_a, w_hit_b};

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed-vector bench for pipe_hazard_ctrl with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int DEPTH = 3;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_valid = 1'b0;
    logic [3:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic        dec_rs1_use = 1'b0, dec_rs2_use = 1'b0;
    logic        dec_wre = 1'b0, dec_load = 1'b0, ex_br_taken = 1'b0;
    logic        stall, flush_fd, flush_de;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] busy_mask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rs1_use (dec_rs1_use),
        .dec_rs2_use (dec_rs2_use),
        .dec_rd      (dec_rd),
        .dec_wre     (dec_wre),
        .dec_load    (dec_load),
        .ex_br_taken (ex_br_taken),
        .stall       (stall),
        .flush_fd    (flush_fd),
        .flush_de    (flush_de),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .busy_mask   (busy_mask)
    );

    // Model: record of every instruction that has left decode, by age.
    typedef struct {
        bit v;
        int rd;
        bit wre;
        bit ld;
    } rec_t;

    rec_t h [1:DEPTH];
    bit   m_init = 1'b0;

    function automatic logic [22:0] pk(input logic s, input logic f1, input logic f2,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [15:0] bm);
        return {s, f1, f2, a, b, bm};
    endfunction

    function automatic logic [22:0] model_out();
        int   sa = 0, sb = 0;
        bit   any = 0, lu = 0, st, ha, hb;
        logic [15:0] bm = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            ha = dec_valid && dec_rs1_use && h[k].v && h[k].wre && (h[k].rd == int'(dec_rs1));
            hb = dec_valid && dec_rs2_use && h[k].v && h[k].wre && (h[k].rd == int'(dec_rs2));
            if (ha || hb) any = 1;
            if (k == 1 && (ha || hb) && h[k].ld) lu = 1;
            if (k <= 3) begin
                if (ha) sa = k;
                if (hb) sb = k;
            end
            if (h[k].v && h[k].wre) bm[h[k].rd] = 1'b1;
        end
        if (FWD) st = lu;
        else begin
            st = any;
            sa = 0;
            sb = 0;
        end
        st = st && !ex_br_taken;
        return pk(st, ex_br_taken, ex_br_taken, 2'(sa), 2'(sb), bm);
    endfunction

    always @(posedge clk) begin
        logic [22:0] ex;
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) h[k] = '{0, 0, 0, 0};
            m_init = 1'b1;
        end else if (m_init) begin
            ex = model_out();
            for (int k = DEPTH; k >= 2; k--) h[k] = h[k-1];
            if (dec_valid && !ex[22] && !ex_br_taken)
                h[1] = '{1, int'(dec_rd), dec_wre, dec_load};
            else
                h[1] = '{0, 0, 0, 0};
        end
    end

    always @(negedge clk) begin
        logic [22:0] ex, got;
        if (m_init) begin
            ex  = model_out();
            got = {stall, flush_fd, flush_de, fwd_a_sel, fwd_b_sel, busy_mask};
            n_tests++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got=%h want=%h", $time, got, ex);
            end
        end
    end

    task automatic lit(input string nm, input logic [22:0] want);
        logic [22:0] got;
        #1;
        got = {stall, flush_fd, flush_de, fwd_a_sel, fwd_b_sel, busy_mask};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic set_dec(input logic v, input logic [3:0] r1, input logic u1,
                           input logic [3:0] r2, input logic u2, input logic [3:0] rd,
                           input logic wre, input logic ld, input logic br);
        dec_valid = v;  dec_rs1 = r1; dec_rs1_use = u1;
        dec_rs2 = r2;   dec_rs2_use = u2;
        dec_rd = rd;    dec_wre = wre; dec_load = ld; ex_br_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH) tick();
        lit(nm, pk(0, 0, 0, 2'd0, 2'd0, 16'h0000));
    endtask

    initial begin
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        lit("reset_idle", pk(0, 0, 0, 2'd0, 2'd0, 16'h0000));

        // EX holds ALU write of r3, decode reads r3 on rs1
        set_dec(1, 0, 0, 0, 0, 4'd3, 1, 0, 0);
        tick();
        set_dec(1, 4'd3, 1, 0, 0, 4'd8, 0, 0, 0);
        lit("alu_ex_rs1", pk(!FWD, 0, 0, FWD ? 2'd1 : 2'd0, 2'd0, 16'h0008));
        drain("drain_a");

        // load r5 in EX, decode reads r5 on rs2
        set_dec(1, 0, 0, 0, 0, 4'd5, 1, 1, 0);
        tick();
        set_dec(1, 0, 0, 4'd5, 1, 4'd0, 0, 0, 0);
        lit("load_use", pk(1, 0, 0, 2'd0, FWD ? 2'd1 : 2'd0, 16'h0020));
        tick();
        lit("load_use_next", pk(!FWD, 0, 0, 2'd0, FWD ? 2'd2 : 2'd0, 16'h0020));
        tick();
        drain("drain_b");

        // r2 pending in both EX and MEM
        set_dec(1, 0, 0, 0, 0, 4'd2, 1, 0, 0);
        tick();
        set_dec(1, 0, 0, 0, 0, 4'd2, 1, 0, 0);
        tick();
        set_dec(1, 4'd2, 1, 0, 0, 4'd0, 0, 0, 0);
        lit("youngest_wins", pk(!FWD, 0, 0, FWD ? 2'd1 : 2'd0, 2'd0, 16'h0004));
        drain("drain_c");

        // load-use coinciding with a taken branch
        set_dec(1, 0, 0, 0, 0, 4'd5, 1, 1, 0);
        tick();
        set_dec(1, 0, 0, 4'd5, 1, 4'd9, 1, 0, 1);
        lit("branch_flush", pk(0, 1, 1, 2'd0, FWD ? 2'd1 : 2'd0, 16'h0020));
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit("branch_bubble", pk(0, 0, 0, 2'd0, 2'd0, 16'h0020));
        drain("drain_d");

        // r7 sitting in WB
        set_dec(1, 0, 0, 0, 0, 4'd7, 1, 0, 0);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_dec(1, 4'd7, 1, 0, 0, 4'd0, 0, 0, 0);
        lit("wb_pending", pk(!FWD, 0, 0, FWD ? 2'd3 : 2'd0, 2'd0, 16'h0080));
        tick();
        lit("wb_retired", pk(0, 0, 0, 2'd0, 2'd0, 16'h0000));
        drain("drain_e");

        // reset in the middle of a load-use stall
        set_dec(1, 0, 0, 0, 0, 4'd4, 1, 1, 0);
        tick();
        set_dec(1, 4'd4, 1, 0, 0, 4'd0, 0, 0, 0);
        lit("stall_pre_reset", pk(1, 0, 0, FWD ? 2'd1 : 2'd0, 2'd0, 16'h0010));
        reset = 1'b1;
        tick();
        lit("stall_reset", pk(0, 0, 0, 2'd0, 2'd0, 16'h0000));
        reset = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // busy mask r3|r5, invalid decode ignores matches, then reset clears
        set_dec(1, 0, 0, 0, 0, 4'd3, 1, 0, 0);
        tick();
        set_dec(1, 0, 0, 0, 0, 4'd5, 1, 0, 0);
        tick();
        set_dec(0, 4'd3, 1, 4'd5, 1, 4'd0, 0, 0, 0);
        lit("dec_invalid", pk(0, 0, 0, 2'd0, 2'd0, 16'h0028));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lit("reset_busy", pk(0, 0, 0, 2'd0, 2'd0, 16'h0000));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-address width (2**REG_AW architectural registers, none hard-wired to zero).
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked stages after decode (EX, MEM, WB for DEPTH=3), legal range 2..6.
REQ-003 SHALL have port clk  input  1  system clock; one clock only, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dec_valid  input  1  decode stage holds a real instruction.
REQ-006 SHALL have ports dec_rs1, dec_rs2  input  REG_AW each  decode source register addresses (a1, a2 fields).
REQ-007 SHALL have ports dec_rs1_use, dec_rs2_use  input  1 each  source operand actually read.
REQ-008 SHALL have port dec_rd  input  REG_AW  decode destination register (a3 field).
REQ-009 SHALL have port dec_wre  input  1  decode instruction writes the register file.
REQ-010 SHALL have port dec_load  input  1  result produced by memory stage (coordinate RAM read), not by ALU.
REQ-011 SHALL have port ex_br_taken  input  1  jump resolved taken in execute.
REQ-012 SHALL have port stall  output  1  hold PC and fetch-decode register; inject bubble into decode-execute.
REQ-013 SHALL have ports flush_fd, flush_de  output  1 each  clear fetch-decode / decode-execute registers to bubble.
REQ-014 SHALL have ports fwd_a_sel, fwd_b_sel  output  2 each  operand source: 0 regfile, 1 stage 1 (EX), 2 stage 2 (MEM), 3 stage 3 (WB).
REQ-015 SHALL have port busy_mask  output  2**REG_AW  bit r set while any tracked stage holds a pending write to r.

Function
REQ-016 SHALL keep a DEPTH-entry shift pipeline of {valid, rd, wre, load}; entry 1 = EX, entry DEPTH = WB.
REQ-017 SHALL each cycle shift entries one stage; entry 1 loads decode fields when dec_valid=1, stall=0, flush_de=0, else loads bubble (valid=0).
REQ-018 SHALL compute stall, flush_fd, flush_de, fwd_*_sel, busy_mask combinationally from current entries and decode inputs (zero-cycle latency).
REQ-019 SHALL match a source only when dec_valid=1, its _use=1, and entry valid=1, wre=1, rd equal.
REQ-020 SHALL select the youngest matching entry (lowest index) when several match; entries beyond stage 3 never forward.
REQ-021 SHALL assert stall for exactly one cycle on load-use: entry 1 matching with load=1; next cycle fwd selects 2.
REQ-022 SHALL, when ex_br_taken=1, assert flush_fd=1 and flush_de=1 and force stall=0 (flush wins over stall same cycle).
REQ-023 SHALL drive fwd_*_sel=0 and stall=0 when dec_valid=0.
REQ-024 SHALL set busy_mask to the OR over valid, wre entries of one-hot(rd).

Reset
REQ-025 SHALL on reset=1 invalidate all entries at the next edge, overriding stall and flush.
REQ-026 SHALL after reset read stall=0, flush_fd=0, flush_de=0, fwd_a_sel=fwd_b_sel=0, busy_mask=0 (given dec_valid=0, ex_br_taken=0).
REQ-027 SHALL discard any in-flight load-use stall if reset asserts mid-stall.

Configuration
REQ-028 SHALL, with PIPE_HAZARD_FWD_EN defined, implement forwarding per REQ-020/021.
REQ-029 SHALL, without PIPE_HAZARD_FWD_EN, tie fwd_*_sel to 0 and assert stall while any entry 1..DEPTH matches a used source.

Structure
REQ-030 SHALL take from shared package pipe_pkg: fwd_sel_e enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and the entry struct typedef hz_entry_t.
REQ-031 SHALL instance sub-module hz_match (one per entry per source) for valid/wre/rd comparison; no other sub-modules.

Verification
REQ-032 SHALL cover: EX writes r3 (ALU), decode reads rs1=r3 -> fwd_a_sel=1, stall=0.
REQ-033 SHALL cover: EX load r5, decode reads rs2=r5 -> stall=1 one cycle, then fwd_b_sel=2, stall=0.
REQ-034 SHALL cover: EX r2, MEM r2 both pending, decode reads r2 -> fwd_a_sel=1 (youngest).
REQ-035 SHALL cover: load-use stall and ex_br_taken=1 same cycle -> stall=0, flush_fd=1, flush_de=1, next cycle entry 1 invalid.
REQ-036 SHALL cover: without PIPE_HAZARD_FWD_EN, WB writes r7, decode reads r7 -> stall=1 until WB entry retires, fwd sels 0.
REQ-037 SHALL cover: reset asserted with busy_mask=16'h0028 -> next cycle busy_mask=0, all outputs 0.
